// File: rtl/wb_arbiter_2to1.sv
// Two-master to one-slave Wishbone arbiter.
// Master 0 (instruction fetch) and master 1 (data port) share one slave port.
// A grant is held for a whole CYC. On a tie the grant goes round-robin
// (FAIR=1) or always to master 0 (FAIR=0). An optional watchdog answers a
// strobe that is never acknowledged with a one-cycle ERR.
module wb_arbiter_2to1 #(
    parameter int FAIR           = 1,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic [31:0] wbm0_addr_i,
    input  logic [31:0] wbm0_dat_i,
    input  logic [3:0]  wbm0_sel_i,
    input  logic        wbm0_cyc_i,
    input  logic        wbm0_stb_i,
    input  logic        wbm0_we_i,
    output logic [31:0] wbm0_dat_o,
    output logic        wbm0_ack_o,
    output logic        wbm0_err_o,

    input  logic [31:0] wbm1_addr_i,
    input  logic [31:0] wbm1_dat_i,
    input  logic [3:0]  wbm1_sel_i,
    input  logic        wbm1_cyc_i,
    input  logic        wbm1_stb_i,
    input  logic        wbm1_we_i,
    output logic [31:0] wbm1_dat_o,
    output logic        wbm1_ack_o,
    output logic        wbm1_err_o,

    output logic [31:0] wbs_addr_o,
    output logic [31:0] wbs_dat_o,
    output logic [3:0]  wbs_sel_o,
    output logic        wbs_cyc_o,
    output logic        wbs_stb_o,
    output logic        wbs_we_o,
    input  logic [31:0] wbs_dat_i,
    input  logic        wbs_ack_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_e;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_e state_q, state_d;
    logic   last_gnt_q, last_gnt_d;
    logic   slave_busy;
    logic   wd_fire;

    // State and last-grant registers; reset leaves master 1 as "last served"
    // so master 0 wins the first tie.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    // Next-state: a grant is held while its CYC stays high and hands over
    // directly to a waiting master without passing through IDLE.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            IDLE: begin
                if (wbm0_cyc_i && wbm1_cyc_i) begin
                    state_d = (FAIR != 0 && !last_gnt_q) ? GNT1 : GNT0;
                end else if (wbm0_cyc_i) begin
                    state_d = GNT0;
                end else if (wbm1_cyc_i) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                last_gnt_d = 1'b0;
                if (!wbm0_cyc_i) begin
                    state_d = wbm1_cyc_i ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                last_gnt_d = 1'b1;
                if (!wbm1_cyc_i) begin
                    state_d = wbm0_cyc_i ? GNT0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request mux towards the slave; IDLE parks every slave signal at zero.
    always_comb begin
        wbs_addr_o = 32'h0;
        wbs_dat_o  = 32'h0;
        wbs_sel_o  = 4'h0;
        wbs_cyc_o  = 1'b0;
        wbs_stb_o  = 1'b0;
        wbs_we_o   = 1'b0;
        case (state_q)
            GNT0: begin
                wbs_addr_o = wbm0_addr_i;
                wbs_dat_o  = wbm0_dat_i;
                wbs_sel_o  = wbm0_sel_i;
                wbs_cyc_o  = wbm0_cyc_i;
                wbs_stb_o  = wbm0_stb_i;
                wbs_we_o   = wbm0_we_i;
            end
            GNT1: begin
                wbs_addr_o = wbm1_addr_i;
                wbs_dat_o  = wbm1_dat_i;
                wbs_sel_o  = wbm1_sel_i;
                wbs_cyc_o  = wbm1_cyc_i;
                wbs_stb_o  = wbm1_stb_i;
                wbs_we_o   = wbm1_we_i;
            end
            default: ;
        endcase
    end

    assign slave_busy = wbs_cyc_o & wbs_stb_o;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wd
            localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
            logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;

            // Watchdog count of consecutive unacknowledged strobe cycles;
            // an ack in the expiry cycle takes precedence over the error.
            always_comb begin
                wd_fire  = slave_busy && !wbs_ack_i && (wd_cnt_q == WD_LAST);
                wd_cnt_d = wd_cnt_q + 1'b1;
                if ((state_d != state_q) || !slave_busy || wbs_ack_i || wd_fire) begin
                    wd_cnt_d = '0;
                end
            end

            // Watchdog counter register.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    wd_cnt_q <= '0;
                end else begin
                    wd_cnt_q <= wd_cnt_d;
                end
            end
        end else begin : g_no_wd
            assign wd_fire = 1'b0;
        end
    endgenerate

    // Responses go only to the granted master; read data is broadcast and
    // qualified by ack at each master.
    assign wbm0_dat_o = wbs_dat_i;
    assign wbm1_dat_o = wbs_dat_i;
    assign wbm0_ack_o = (state_q == GNT0) & wbs_ack_i & wbm0_cyc_i & wbm0_stb_i;
    assign wbm1_ack_o = (state_q == GNT1) & wbs_ack_i & wbm1_cyc_i & wbm1_stb_i;
    assign wbm0_err_o = (state_q == GNT0) & wd_fire;
    assign wbm1_err_o = (state_q == GNT1) & wd_fire;

endmodule

// File: tb/tb_wb_arbiter_2to1.sv
// Testbench for wb_arbiter_2to1: two instances (FAIR=1 with a 4-cycle
// watchdog, FAIR=0 without watchdog) share one stimulus stream. Expected
// outputs come from a transaction-level ownership model and are queued;
// a monitor on the falling edge pops and compares.
module tb_wb_arbiter_2to1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        cyc;
        logic        stb;
        logic        we;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        a0;
        logic        a1;
        logic        e0;
        logic        e1;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] m_addr [2];
    logic [31:0] m_dat  [2];
    logic [3:0]  m_sel  [2];
    logic        m_cyc  [2];
    logic        m_stb  [2];
    logic        m_we   [2];
    logic [31:0] s_dat;
    logic        s_ack;

    logic [31:0] o_addr [2];
    logic [31:0] o_dat  [2];
    logic [3:0]  o_sel  [2];
    logic        o_cyc  [2];
    logic        o_stb  [2];
    logic        o_we   [2];
    logic [31:0] o_d0   [2];
    logic [31:0] o_d1   [2];
    logic        o_a0   [2];
    logic        o_a1   [2];
    logic        o_e0   [2];
    logic        o_e1   [2];

    wb_arbiter_2to1 #(.FAIR(1), .TIMEOUT_CYCLES(4)) dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .wbm0_addr_i(m_addr[0]), .wbm0_dat_i(m_dat[0]), .wbm0_sel_i(m_sel[0]),
        .wbm0_cyc_i(m_cyc[0]), .wbm0_stb_i(m_stb[0]), .wbm0_we_i(m_we[0]),
        .wbm0_dat_o(o_d0[0]), .wbm0_ack_o(o_a0[0]), .wbm0_err_o(o_e0[0]),
        .wbm1_addr_i(m_addr[1]), .wbm1_dat_i(m_dat[1]), .wbm1_sel_i(m_sel[1]),
        .wbm1_cyc_i(m_cyc[1]), .wbm1_stb_i(m_stb[1]), .wbm1_we_i(m_we[1]),
        .wbm1_dat_o(o_d1[0]), .wbm1_ack_o(o_a1[0]), .wbm1_err_o(o_e1[0]),
        .wbs_addr_o(o_addr[0]), .wbs_dat_o(o_dat[0]), .wbs_sel_o(o_sel[0]),
        .wbs_cyc_o(o_cyc[0]), .wbs_stb_o(o_stb[0]), .wbs_we_o(o_we[0]),
        .wbs_dat_i(s_dat), .wbs_ack_i(s_ack)
    );

    wb_arbiter_2to1 #(.FAIR(0), .TIMEOUT_CYCLES(0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .wbm0_addr_i(m_addr[0]), .wbm0_dat_i(m_dat[0]), .wbm0_sel_i(m_sel[0]),
        .wbm0_cyc_i(m_cyc[0]), .wbm0_stb_i(m_stb[0]), .wbm0_we_i(m_we[0]),
        .wbm0_dat_o(o_d0[1]), .wbm0_ack_o(o_a0[1]), .wbm0_err_o(o_e0[1]),
        .wbm1_addr_i(m_addr[1]), .wbm1_dat_i(m_dat[1]), .wbm1_sel_i(m_sel[1]),
        .wbm1_cyc_i(m_cyc[1]), .wbm1_stb_i(m_stb[1]), .wbm1_we_i(m_we[1]),
        .wbm1_dat_o(o_d1[1]), .wbm1_ack_o(o_a1[1]), .wbm1_err_o(o_e1[1]),
        .wbs_addr_o(o_addr[1]), .wbs_dat_o(o_dat[1]), .wbs_sel_o(o_sel[1]),
        .wbs_cyc_o(o_cyc[1]), .wbs_stb_o(o_stb[1]), .wbs_we_o(o_we[1]),
        .wbs_dat_i(s_dat), .wbs_ack_i(s_ack)
    );

    // Reference model: who owns the slave, who was served last, and how long
    // the current strobe has waited for an ack.
    int fair_p [2] = '{1, 0};
    int tmo_p  [2] = '{4, 0};
    int owner  [2];
    int last   [2];
    int waitc  [2];

    obs_t q0 [$];
    obs_t q1 [$];
    int vectors = 0;
    int miscompares = 0;

    function automatic obs_t actual(input int k);
        obs_t o;
        o = {o_addr[k], o_dat[k], o_sel[k], o_cyc[k], o_stb[k], o_we[k],
             o_d0[k], o_d1[k], o_a0[k], o_a1[k], o_e0[k], o_e1[k]};
        return o;
    endfunction

    function automatic logic timed_out(input int k);
        int w;
        w = owner[k];
        if (w < 0 || tmo_p[k] == 0) return 1'b0;
        return m_cyc[w] && m_stb[w] && !s_ack && (waitc[k] == tmo_p[k] - 1);
    endfunction

    function automatic obs_t expect_out(input int k);
        obs_t o;
        int w;
        logic hit;
        o = '0;
        o.d0 = s_dat;
        o.d1 = s_dat;
        w = owner[k];
        if (w >= 0) begin
            o.addr = m_addr[w];
            o.dat  = m_dat[w];
            o.sel  = m_sel[w];
            o.cyc  = m_cyc[w];
            o.stb  = m_stb[w];
            o.we   = m_we[w];
            hit = m_cyc[w] && m_stb[w];
            if (w == 0) begin
                o.a0 = s_ack && hit;
                o.e0 = timed_out(k);
            end else begin
                o.a1 = s_ack && hit;
                o.e1 = timed_out(k);
            end
        end
        return o;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            owner[k] = -1;
            last[k]  = 1;
            waitc[k] = 0;
        end
    endtask

    task automatic model_edge(input int k);
        int nxt;
        logic fired;
        logic hit;
        fired = timed_out(k);
        if (owner[k] < 0) begin
            if (m_cyc[0] && m_cyc[1]) nxt = (fair_p[k] != 0) ? 1 - last[k] : 0;
            else if (m_cyc[0])        nxt = 0;
            else if (m_cyc[1])        nxt = 1;
            else                      nxt = -1;
            hit = 1'b0;
        end else begin
            hit = m_cyc[owner[k]] && m_stb[owner[k]];
            if (m_cyc[owner[k]])          nxt = owner[k];
            else if (m_cyc[1 - owner[k]]) nxt = 1 - owner[k];
            else                          nxt = -1;
            last[k] = owner[k];
        end
        if (nxt != owner[k] || !hit || s_ack || fired) waitc[k] = 0;
        else waitc[k] = waitc[k] + 1;
        owner[k] = nxt;
    endtask

    task automatic chk(input int k, input obs_t act, input obs_t exp, input string tag);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d t=%0t: got %h expected %h", tag, k, $time, act, exp);
        end
    endtask

    // Monitor: compare each queued expectation against the settled outputs.
    always @(negedge clk) begin
        if (q0.size() > 0) chk(0, actual(0), q0.pop_front(), "cycle");
        if (q1.size() > 0) chk(1, actual(1), q1.pop_front(), "cycle");
    end

    task automatic set_m(input int i, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] addr, input logic [31:0] dat, input logic [3:0] sel);
        m_cyc[i] = cyc; m_stb[i] = stb; m_we[i] = we;
        m_addr[i] = addr; m_dat[i] = dat; m_sel[i] = sel;
    endtask

    task automatic idle_all();
        set_m(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        set_m(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        s_ack = 1'b0;
    endtask

    // One bus cycle: queue expectations for the inputs now applied, then
    // advance the model across the rising edge.
    task automatic cycle();
        q0.push_back(expect_out(0));
        q1.push_back(expect_out(1));
        @(posedge clk);
        if (!rst_n) model_reset();
        else for (int k = 0; k < 2; k++) model_edge(k);
        #1;
    endtask

    initial begin
        idle_all();
        s_dat = 32'hA5A5_0001;
        model_reset();
        #2;
        chk(0, actual(0), expect_out(0), "reset");
        chk(1, actual(1), expect_out(1), "reset");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Master 0 alone reads 0x100.
        set_m(0, 1, 1, 0, 32'h100, 32'h0, 4'hF);
        s_dat = 32'h1234_5678;
        cycle();
        s_ack = 1'b1;
        cycle();
        idle_all();
        cycle();

        // Both request; master 0 drops CYC after three cycles.
        set_m(0, 1, 1, 0, 32'h200, 32'h0, 4'hF);
        set_m(1, 1, 1, 1, 32'h300, 32'h1111_2222, 4'hF);
        s_ack = 1'b1;
        for (int c = 0; c < 3; c++) cycle();
        set_m(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        for (int c = 0; c < 2; c++) cycle();
        idle_all();
        cycle();

        // Back-to-back single-beat cycles: a master drops CYC after its ack
        // and re-requests on the following cycle.
        s_ack = 1'b1;
        set_m(0, 1, 1, 0, 32'h400, 32'h0, 4'hF);
        set_m(1, 1, 1, 0, 32'h500, 32'h0, 4'hF);
        for (int c = 0; c < 12; c++) begin
            logic g0, g1;
            g0 = o_a0[0];
            g1 = o_a1[0];
            cycle();
            m_cyc[0] = !g0; m_stb[0] = !g0;
            m_cyc[1] = !g1; m_stb[1] = !g1;
        end
        idle_all();
        cycle();

        // Master 0 holds CYC for three write beats while master 1 waits.
        set_m(0, 1, 1, 1, 32'h600, 32'hDEAD_BEEF, 4'b0011);
        set_m(1, 1, 1, 0, 32'h700, 32'h0, 4'hF);
        s_ack = 1'b1;
        cycle();
        for (int c = 0; c < 3; c++) cycle();
        set_m(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        cycle();
        cycle();
        idle_all();
        cycle();

        // Master 1 strobes an unmapped address that never acks.
        set_m(1, 1, 1, 0, 32'hFFFF_0000, 32'h0, 4'hF);
        s_ack = 1'b0;
        for (int c = 0; c < 10; c++) cycle();
        idle_all();
        cycle();

        // Asynchronous reset in the middle of a master 1 write.
        set_m(1, 1, 1, 1, 32'h800, 32'hCAFE_F00D, 4'hF);
        s_ack = 1'b0;
        cycle();
        s_ack = 1'b1;
        #1;
        chk(0, actual(0), expect_out(0), "pre_reset");
        chk(1, actual(1), expect_out(1), "pre_reset");
        rst_n = 1'b0;
        #1;
        model_reset();
        chk(0, actual(0), expect_out(0), "async_reset");
        chk(1, actual(1), expect_out(1), "async_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_m(0, 1, 1, 0, 32'h900, 32'h0, 4'hF);
        set_m(1, 1, 1, 0, 32'hA00, 32'h0, 4'hF);
        for (int c = 0; c < 3; c++) cycle();
        idle_all();
        cycle();

        // Randomised traffic: masters hold CYC for random spans, the slave
        // acks at random.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 3) == 0) m_cyc[i] = !m_cyc[i];
                m_stb[i]  = m_cyc[i] && ($urandom_range(0, 3) != 0);
                m_we[i]   = 1'($urandom_range(0, 1));
                m_addr[i] = $urandom;
                m_dat[i]  = $urandom;
                m_sel[i]  = 4'($urandom_range(0, 15));
            end
            s_ack = ($urandom_range(0, 2) == 0);
            s_dat = $urandom;
            cycle();
        end
        idle_all();
        cycle();
        @(negedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
